// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dm_arbiter data-memory front end.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRmwWr
    } state_e;

    typedef enum logic {
        OwnCpu,
        OwnDbg
    } owner_e;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

endpackage

// File: rtl/dm_arbiter_if.sv
// One requester port of dm_arbiter: request/grant handshake, done pulse and read data.
interface dm_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, done, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, done, rdata
    );
endinterface

// File: rtl/dm_be_merge.sv
// Combinational 4-lane byte merge: lanes with be set take the new word, others keep the old.
module dm_be_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  be_i,
    output logic [31:0] merged_o
);
    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage and the debug port.
// Define DM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU always wins a tie.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    dm_arbiter_if.slave       cpu_io,
    dm_arbiter_if.slave       dbg_io,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [ADDR_W-1:0] WordMask = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              cpu_done_q, cpu_done_d;
    logic              dbg_done_q, dbg_done_d;

    logic              cpu_win, dbg_win, grant, tie_cpu, partial, last_cycle;
    logic [DATA_W-1:0] merged;

`ifdef DM_ARB_RR_EN
    owner_e last_q;

    // Resetting to OwnDbg hands the first tie to the CPU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= OwnDbg;
        end else if (grant) begin
            last_q <= cpu_win ? OwnCpu : OwnDbg;
        end
    end

    assign tie_cpu = (last_q == OwnDbg);
`else
    assign tie_cpu = 1'b1;
`endif

    // Grants are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (reset && state_q == StIdle) begin
            if (cpu_io.req && dbg_io.req) begin
                cpu_win = tie_cpu;
                dbg_win = !tie_cpu;
            end else begin
                cpu_win = cpu_io.req;
                dbg_win = dbg_io.req;
            end
        end
    end

    assign grant      = cpu_win | dbg_win;
    assign partial    = we_q && (be_q != BE_FULL) && (be_q != BE_NONE);
    assign last_cycle = ((state_q == StAccess) && !partial) || (state_q == StRmwWr);

    dm_be_merge u_merge (
        .old_i    (mem_rdata),
        .new_i    (wdata_q),
        .be_i     (be_q),
        .merged_o (merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant) state_d = StAccess;
            StAccess: state_d = partial ? StRmwWr : StIdle;
            StRmwWr:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_done_d  = 1'b0;
        dbg_done_d  = 1'b0;
        if (grant) begin
            owner_d = cpu_win ? OwnCpu : OwnDbg;
            we_d    = cpu_win ? cpu_io.we : dbg_io.we;
            be_d    = cpu_win ? cpu_io.be : dbg_io.be;
            addr_d  = (cpu_win ? cpu_io.addr : dbg_io.addr) & WordMask;
            wdata_d = cpu_win ? cpu_io.wdata : dbg_io.wdata;
        end
        if (state_q == StAccess && partial) begin
            merge_d = merged;
        end
        if (state_q == StAccess && !we_q) begin
            if (owner_q == OwnCpu) cpu_rdata_d = mem_rdata;
            else                   dbg_rdata_d = mem_rdata;
        end
        if (last_cycle) begin
            cpu_done_d = (owner_q == OwnCpu);
            dbg_done_d = (owner_q == OwnDbg);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= OwnCpu;
            we_q        <= 1'b0;
            be_q        <= BE_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            merge_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            dbg_done_q  <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_done_q  <= cpu_done_d;
            dbg_done_q  <= dbg_done_d;
        end
    end

    // mem_we follows state_q, so an asynchronous reset drops it immediately.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            StAccess: begin
                if (!we_q)                 mem_re = 1'b1;
                else if (be_q == BE_FULL)  mem_we = 1'b1;
                else if (be_q != BE_NONE)  mem_re = 1'b1;
            end
            StRmwWr: begin
                mem_we    = 1'b1;
                mem_wdata = merge_q;
            end
            default: ;
        endcase
    end

    assign cpu_io.gnt   = cpu_win;
    assign dbg_io.gnt   = dbg_win;
    assign cpu_io.done  = cpu_done_q;
    assign dbg_io.done  = dbg_done_q;
    assign cpu_io.rdata = cpu_rdata_q;
    assign dbg_io.rdata = dbg_rdata_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed cases plus random two-port traffic against a transaction model.
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if cpu_if ();
    dm_arbiter_if dbg_if ();

    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    // Behavioural dm: combinational read, word write on the edge, plus a backdoor preload port.
    logic [31:0] dm_mem [64];
    logic        bk_we = 1'b0;
    logic [5:0]  bk_idx = '0;
    logic [31:0] bk_val = '0;
    assign mem_rdata = dm_mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) dm_mem[mem_addr[7:2]] <= mem_wdata;
        if (bk_we)  dm_mem[bk_idx] <= bk_val;
    end

    dm_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_io    (cpu_if),
        .dbg_io    (dbg_if),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Transaction-level model: one outstanding access, scheduled by its phase since the grant.
    logic [31:0] ref_mem [64];
    logic [31:0] m_rdata [2];
    logic        m_last;
    logic        act_v, act_own, act_we;
    logic [3:0]  act_be;
    logic [31:0] act_addr, act_wdata, act_rd, act_mrg;
    int          act_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] merge_ref(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        act_v = 1'b0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_last = 1'b1;
        cyc = 0;
    endtask

    task automatic model_step();
        logic e_cg, e_dg, e_cd, e_dd, e_re, e_we, r0, r1, win, tie;
        logic [31:0] e_addr, e_wd;
        int ph, dph;
        e_cg = 0; e_dg = 0; e_cd = 0; e_dd = 0; e_re = 0; e_we = 0;
        e_addr = '0; e_wd = '0;
        if (act_v) begin
            ph  = cyc - act_start;
            dph = (act_we && act_be != 4'h0 && act_be != 4'hF) ? 3 : 2;
            if (ph == 1) begin
                e_addr = act_addr;
                if (!act_we) begin
                    e_re = 1; act_rd = ref_mem[act_addr[7:2]];
                end else if (act_be == 4'hF) begin
                    e_we = 1; e_wd = act_wdata; ref_mem[act_addr[7:2]] = act_wdata;
                end else if (act_be != 4'h0) begin
                    e_re = 1; act_mrg = merge_ref(ref_mem[act_addr[7:2]], act_wdata, act_be);
                end
            end else if (ph == 2 && dph == 3) begin
                e_addr = act_addr; e_we = 1; e_wd = act_mrg; ref_mem[act_addr[7:2]] = act_mrg;
            end
            if (ph == dph) begin
                if (act_own) e_dd = 1; else e_cd = 1;
                if (!act_we) m_rdata[act_own] = act_rd;
                act_v = 0;
            end
        end
        if (!act_v) begin
            r0 = cpu_if.req;
            r1 = dbg_if.req;
            if (r0 || r1) begin
`ifdef DM_ARB_RR_EN
                tie = !m_last;
`else
                tie = 1'b0;
`endif
                win = (r0 && r1) ? tie : r1;
                if (win) e_dg = 1; else e_cg = 1;
                act_v = 1; act_own = win; act_start = cyc; m_last = win;
                act_we    = win ? dbg_if.we : cpu_if.we;
                act_be    = win ? dbg_if.be : cpu_if.be;
                act_addr  = (win ? dbg_if.addr : cpu_if.addr) & 32'hFFFF_FFFC;
                act_wdata = win ? dbg_if.wdata : cpu_if.wdata;
            end
        end
        chk("cpu_gnt", cpu_if.gnt, e_cg);
        chk("dbg_gnt", dbg_if.gnt, e_dg);
        chk("cpu_done", cpu_if.done, e_cd);
        chk("dbg_done", dbg_if.done, e_dd);
        chk("cpu_rdata", cpu_if.rdata, m_rdata[0]);
        chk("dbg_rdata", dbg_if.rdata, m_rdata[1]);
        chk("mem_re", mem_re, e_re);
        chk("mem_we", mem_we, e_we);
        if (e_re || e_we) chk("mem_addr", mem_addr, e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wd);
        cyc++;
    endtask

    task automatic cyc_step();
        @(negedge clk);
        model_step();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req(output logic req, output logic we, output logic [3:0] be,
                            output logic [31:0] addr, output logic [31:0] wdata);
        req   = ($urandom_range(0, 3) != 0);
        we    = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 3))
            0:       be = 4'hF;
            1:       be = 4'h0;
            default: be = 4'($urandom_range(1, 14));
        endcase
        addr  = $urandom;
        wdata = $urandom;
    endtask

    task automatic set_cpu(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
        cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.be = be;
        cpu_if.addr = addr; cpu_if.wdata = wdata;
    endtask

    int seq [8];
    int n, cnt;
    logic gc, gd, dg_seen;
    logic [31:0] v, saved;

    initial begin
        cpu_if.req = 1'b1; cpu_if.we = 0; cpu_if.be = 4'hF; cpu_if.addr = 0; cpu_if.wdata = 0;
        dbg_if.req = 1'b1; dbg_if.we = 0; dbg_if.be = 4'hF; dbg_if.addr = 0; dbg_if.wdata = 0;
        #2;
        chk("rst_cpu_gnt", cpu_if.gnt, 0);
        chk("rst_dbg_gnt", dbg_if.gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_done", cpu_if.done, 0);
        chk("rst_cpu_rdata", cpu_if.rdata, 0);
        cpu_if.req = 1'b0;
        dbg_if.req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            v = (i == 4 || i == 8 || i == 12) ? 32'h1122_3344 : $urandom;
            ref_mem[i] = v;
            bk_we = 1'b1; bk_idx = 6'(i); bk_val = v;
            nxt();
        end
        bk_we = 1'b0;
        nxt();
        reset = 1'b1;
        model_reset();

        // CPU load from 0x10.
        set_cpu(0, 4'hF, 32'h0000_0010, 32'h0);
        cyc_step(); chk("t1_gnt", cpu_if.gnt, 1); nxt(); cpu_if.req = 0;
        cyc_step(); chk("t1_re", mem_re, 1); chk("t1_addr", mem_addr, 32'h10); nxt();
        cyc_step(); chk("t1_done", cpu_if.done, 1); chk("t1_rdata", cpu_if.rdata, 32'h1122_3344);
        nxt();

        // Full-word store to unaligned 0x7.
        set_cpu(1, 4'hF, 32'h0000_0007, 32'hDEAD_BEEF);
        cyc_step(); chk("t2_gnt", cpu_if.gnt, 1); nxt(); cpu_if.req = 0;
        cyc_step(); chk("t2_we", mem_we, 1); chk("t2_addr", mem_addr, 32'h4); nxt();
        cyc_step(); chk("t2_done", cpu_if.done, 1); chk("t2_word", dm_mem[1], 32'hDEAD_BEEF);
        nxt();

        // Partial store: read-modify-write.
        set_cpu(1, 4'b0010, 32'h0000_0020, 32'h0000_AB00);
        cnt = 0;
        cyc_step(); cnt += int'(mem_we); nxt(); cpu_if.req = 0;
        cyc_step(); cnt += int'(mem_we); chk("t3_re", mem_re, 1); nxt();
        cyc_step(); cnt += int'(mem_we); chk("t3_wdata", mem_wdata, 32'h1122_AB44); nxt();
        cyc_step(); cnt += int'(mem_we); chk("t3_done", cpu_if.done, 1);
        chk("t3_we_cycles", cnt, 1); chk("t3_word", dm_mem[8], 32'h1122_AB44);
        nxt();

        // Continuous contention for 8 transactions, from a fresh reset.
        reset = 1'b0; nxt(); reset = 1'b1; model_reset();
        set_cpu(0, 4'hF, 32'h10, 32'h0);
        dbg_if.req = 1; dbg_if.we = 0; dbg_if.be = 4'hF; dbg_if.addr = 32'h10;
        n = 0; dg_seen = 0;
        for (int k = 0; k < 40 && n < 8; k++) begin
            cyc_step();
            if (cpu_if.gnt && n < 8) begin seq[n] = 0; n++; end
            if (dbg_if.gnt && n < 8) begin seq[n] = 1; n++; dg_seen = 1; end
            nxt();
        end
        cpu_if.req = 0; dbg_if.req = 0;
        chk("t4_count", n, 8);
        for (int i = 0; i < 8; i++) begin
`ifdef DM_ARB_RR_EN
            chk("t4_order", seq[i], i % 2);
`else
            chk("t4_order", seq[i], 0);
`endif
        end
`ifndef DM_ARB_RR_EN
        chk("t4_dbg_starved", dg_seen, 0);
`endif
        for (int k = 0; k < 3; k++) begin cyc_step(); nxt(); end

        // Reset pulled during RMW_WR.
        set_cpu(1, 4'b0010, 32'h0000_0030, 32'h0000_AB00);
        cyc_step(); nxt(); cpu_if.req = 0;
        cyc_step(); nxt();
        #1; chk("t5_we_before", mem_we, 1);
        reset = 1'b0;
        #1; chk("t5_we_async", mem_we, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t5_no_done", cpu_if.done, 0); chk("t5_no_we", mem_we, 0);
            nxt();
        end
        chk("t5_word", dm_mem[12], 32'h1122_3344);
        reset = 1'b1; model_reset();

        // Store with no byte enables.
        saved = ref_mem[16];
        set_cpu(1, 4'h0, 32'h0000_0040, 32'hFFFF_FFFF);
        cnt = 0;
        cyc_step(); cnt += int'(mem_we | mem_re); chk("t6_gnt", cpu_if.gnt, 1); nxt();
        cpu_if.req = 0;
        cyc_step(); cnt += int'(mem_we | mem_re); nxt();
        cyc_step(); cnt += int'(mem_we | mem_re); chk("t6_done", cpu_if.done, 1); nxt();
        chk("t6_no_access", cnt, 0); chk("t6_word", dm_mem[16], saved);

        // Random two-port traffic.
        rand_req(cpu_if.req, cpu_if.we, cpu_if.be, cpu_if.addr, cpu_if.wdata);
        rand_req(dbg_if.req, dbg_if.we, dbg_if.be, dbg_if.addr, dbg_if.wdata);
        for (int k = 0; k < 600; k++) begin
            cyc_step();
            gc = cpu_if.gnt; gd = dbg_if.gnt;
            nxt();
            if (gc || !cpu_if.req) rand_req(cpu_if.req, cpu_if.we, cpu_if.be, cpu_if.addr, cpu_if.wdata);
            if (gd || !dbg_if.req) rand_req(dbg_if.req, dbg_if.we, dbg_if.be, dbg_if.addr, dbg_if.wdata);
        end
        cpu_if.req = 0; dbg_if.req = 0;
        for (int k = 0; k < 6 && act_v; k++) begin cyc_step(); nxt(); end
        chk("drain_idle", act_v, 0);
        for (int i = 0; i < 64; i++) chk("final_mem", dm_mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
